// File: rtl/minus_diff_accumulator.sv
// -----------------------------------------------------------------------------
// minus_diff_accumulator
//
// Purpose:
//   Sums WINDOW consecutive difference samples from the upstream subtractor.
//   Emits one block sum per WINDOW accepted samples over a valid/ready output.
//   The sum is held until the consumer takes it.
//
// Optional feature (macro MINUS_DIFF_ACC_ABS_EN):
//   When defined, each sample is replaced by its absolute value before it is
//   accumulated. The result is then an unsigned sum of absolute differences.
//   When undefined, samples are accumulated as signed two's-complement values.
//
// Parameters:
//   DATA_W - width of the incoming difference sample
//   WINDOW - samples per sum (power of two, >= 2)
//   ACC_W  - accumulator/output width, DATA_W + log2(WINDOW) (derived)
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   io_in_valid  in   sample valid
//   io_in_ready  out  block can accept a sample
//   io_in_bits   in   difference sample, two's complement
//   io_flush     in   synchronous clear of the partial window
//   io_out_valid out  windowed sum valid
//   io_out_ready in   consumer accepts the sum
//   io_out_bits  out  windowed sum (registered)
//   io_count     out  samples accepted in the current partial window
// -----------------------------------------------------------------------------
module minus_diff_accumulator #(
  parameter  int DATA_W = 16,
  parameter  int WINDOW = 16,
  localparam int CNT_W  = $clog2(WINDOW),
  localparam int ACC_W  = DATA_W + CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [DATA_W-1:0] io_in_bits,
  input  logic              io_flush,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [ACC_W-1:0]  io_out_bits,
  output logic [CNT_W-1:0]  io_count
);

  // Widen one sample to accumulator width. ACC_W >= DATA_W+1 always holds,
  // so the absolute-value path never loses the magnitude of the most
  // negative input.
  function automatic logic [ACC_W-1:0] ext_sample(input logic [DATA_W-1:0] s);
`ifdef MINUS_DIFF_ACC_ABS_EN
    logic [DATA_W:0] mag;
    mag = s[DATA_W-1] ? ({1'b0, ~s} + 1'b1) : {1'b0, s};
    return ACC_W'(mag);
`else
    logic signed [DATA_W-1:0] sv;
    sv = $signed(s);
    return ACC_W'(sv);
`endif
  endfunction

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_bits;

  logic             w_accept;
  logic             w_last;
  logic [ACC_W-1:0] w_sum;

  // Ready is combinational so a pending sum and a new sample can be
  // exchanged in the same cycle (full throughput on back-to-back windows).
  assign io_in_ready = !io_flush && (!r_out_valid || io_out_ready);
  assign w_accept    = io_in_valid && io_in_ready;
  assign w_last      = (r_count == CNT_W'(WINDOW - 1));
  assign w_sum       = r_acc + ext_sample(io_in_bits);

  // Accumulation stage: partial window sum and sample count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (io_flush) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_acc   <= '0;
        r_count <= '0;
      end else begin
        r_acc   <= w_sum;
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  // Output stage: a completing window overrides the clear from a handshake
  // in the same cycle. Flush never touches a pending result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_bits  <= '0;
    end else if (w_accept && w_last) begin
      r_out_valid <= 1'b1;
      r_out_bits  <= w_sum;
    end else if (r_out_valid && io_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign io_out_valid = r_out_valid;
  assign io_out_bits  = r_out_bits;
  assign io_count     = r_count;

endmodule

// File: tb/tb_minus_diff_accumulator.sv
module tb_minus_diff_accumulator;

  logic        clock;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [15:0] io_in_bits;
  logic        io_flush;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [19:0] io_out_bits;
  logic [3:0]  io_count;

  minus_diff_accumulator dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_bits   (io_in_bits),
    .io_flush     (io_flush),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_bits  (io_out_bits),
    .io_count     (io_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int stalls = 0;
  logic [19:0] exp_q[$];
  int          pop_cyc[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every output handshake pops one expected sum.
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge clock);
      if (reset && io_out_valid && io_out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {12'h0, io_out_bits}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("window_sum", {12'h0, io_out_bits}, {12'h0, e});
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  // Offers one sample and returns at posedge+1 after it is accepted.
  task automatic send(input logic [15:0] v);
    int n;
    n = 0;
    io_in_valid = 1'b1;
    io_in_bits  = v;
    @(negedge clock);
    while (!io_in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("send_timeout", 32'd0, 32'd1);
    stalls += n;
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
  endtask

  task automatic send_n(input int cnt, input logic [15:0] v);
    for (int i = 0; i < cnt; i++) send(v);
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    io_in_valid  = 1'b0;
    io_in_bits   = '0;
    io_flush     = 1'b0;
    io_out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", {31'h0, io_out_valid}, 32'd0);
    check("rst_out_bits",  {12'h0, io_out_bits}, 32'd0);
    check("rst_count",     {28'h0, io_count}, 32'd0);
    reset = 1'b1;
    #1;
    check("rst_in_ready",  {31'h0, io_in_ready}, 32'd1);

    // Basic signed sum 1..16 = 136, visible one cycle after last accept
    exp_q.push_back(20'd136);
    for (int i = 1; i <= 16; i++) send(16'(i));
    check("basic_latency_valid", {31'h0, io_out_valid}, 32'd1);
    check("basic_count_wrap",    {28'h0, io_count}, 32'd0);
    drain(2);

    // Negative extremes
    exp_q.push_back(20'h80000);
    send_n(16, 16'h8000);
    drain(2);
`ifdef MINUS_DIFF_ACC_ABS_EN
    exp_q.push_back(20'd16);
`else
    exp_q.push_back(20'hFFFF0);
`endif
    send_n(16, 16'hFFFF);
    drain(2);

    // Backpressure: window of 5s completes with consumer stalled
    io_out_ready = 1'b0;
    exp_q.push_back(20'd80);
    send_n(16, 16'd5);
    io_in_valid = 1'b1;
    io_in_bits  = 16'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_in_ready_low", {31'h0, io_in_ready}, 32'd0);
      check("bp_out_hold",     {12'h0, io_out_bits}, 32'd80);
      check("bp_valid_hold",   {31'h0, io_out_valid}, 32'd1);
    end
    @(posedge clock);
    #1;
    io_out_ready = 1'b1;
    @(negedge clock);
    check("bp_resume_ready", {31'h0, io_in_ready}, 32'd1);
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
    check("bp_resume_count", {28'h0, io_count}, 32'd1);
    check("bp_out_cleared",  {31'h0, io_out_valid}, 32'd0);
    exp_q.push_back(20'd112);
    send_n(15, 16'd7);
    drain(2);

    // Back-to-back windows at full throughput
    pop_cyc.delete();
    stalls = 0;
    exp_q.push_back(20'd48);
    exp_q.push_back(20'd48);
    send_n(32, 16'd3);
    drain(3);
    check("b2b_no_bubble", stalls, 32'd0);
    check("b2b_outputs", pop_cyc.size(), 32'd2);
    if (pop_cyc.size() == 2)
      check("b2b_spacing", pop_cyc[1] - pop_cyc[0], 32'd16);

    // Flush drops the partial window
    send_n(5, 16'd10);
    check("flush_pre_count", {28'h0, io_count}, 32'd5);
    io_flush    = 1'b1;
    io_in_valid = 1'b1;
    io_in_bits  = 16'd10;
    @(negedge clock);
    check("flush_in_ready", {31'h0, io_in_ready}, 32'd0);
    @(posedge clock);
    #1;
    io_flush    = 1'b0;
    io_in_valid = 1'b0;
    check("flush_count", {28'h0, io_count}, 32'd0);
    exp_q.push_back(20'd16);
    send_n(16, 16'd1);
    drain(2);

    // Asynchronous reset mid-window
    send_n(7, 16'd2);
    check("rstmid_pre_count", {28'h0, io_count}, 32'd7);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("rstmid_count", {28'h0, io_count}, 32'd0);
    check("rstmid_valid", {31'h0, io_out_valid}, 32'd0);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    exp_q.push_back(20'd32);
    send_n(16, 16'd2);
    drain(4);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/minus_diff_accumulator.md
Name: minus_diff_accumulator

Overview:
- Downstream consumer of the 16-bit subtractor stage (io_out = io_in1 - io_in2).
- Takes the difference stream over a valid/ready handshake and sums WINDOW consecutive differences as two's-complement values.
- Emits one windowed sum per WINDOW accepted samples on a valid/ready output, holding it until the consumer takes it.
- Feeds statistics/threshold logic that needs block-level differences rather than per-sample ones.

Parameters:
- DATA_W, 16: width of the incoming difference; matches the subtractor output.
- WINDOW, 16: samples per sum; power of two, minimum 2.
- ACC_W, DATA_W+log2(WINDOW): accumulator and output width; derived, not overridden.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- io_in_valid  input  1  difference sample valid.
- io_in_ready  output  1  block can accept a sample.
- io_in_bits  input  DATA_W  difference sample, two's complement.
- io_flush  input  1  synchronous clear of the partial window.
- io_out_valid  output  1  windowed sum valid.
- io_out_ready  input  1  consumer accepts the sum.
- io_out_bits  output  ACC_W  windowed sum.
- io_count  output  log2(WINDOW)  samples accepted in the current partial window.

Behaviour:
- Reset (reset low, asynchronous): acc=0, count=0, io_out_valid=0, io_out_bits=0, io_count=0. Leaving reset is synchronous to clock.
- Accept condition: accept = io_in_valid && io_in_ready.
- Ready rule: io_in_ready = !io_flush && (!io_out_valid || io_out_ready). It is combinational from io_out_ready and io_flush.
- Sign handling: io_in_bits is sign-extended to ACC_W before addition. No overflow is possible at the derived width.
- Accept with count < WINDOW-1: acc <= acc + ext(in); count <= count+1.
- Accept with count == WINDOW-1:
  - io_out_bits <= acc + ext(in); io_out_valid <= 1.
  - acc <= 0; count <= 0 (wrap).
  - Latency from the last sample accepted to io_out_valid high is 1 cycle.
- Output hold: io_out_bits and io_out_valid are held stable while io_out_valid && !io_out_ready.
- Output handshake: io_out_valid && io_out_ready clears io_out_valid next cycle, unless a new window completes in the same cycle. In that case io_out_valid stays 1 and io_out_bits takes the new sum. Back-to-back windows therefore run at full throughput.
- Backpressure: with an output pending and io_out_ready=0, io_in_ready=0. No sample is dropped.
- Flush:
  - io_flush=1 sets acc <= 0 and count <= 0 next cycle.
  - io_in_ready is forced low, so no sample is accepted in a flush cycle.
  - A pending output is unaffected and still completes its handshake.
- Mid-window reset: the partial sum and any pending output are discarded. Nothing is emitted afterwards for the interrupted window.
- io_count mirrors the count register.
- io_out_bits is registered. No combinational path from io_in_bits to io_out_bits.

Optional Feature:
- Macro: MINUS_DIFF_ACC_ABS_EN.
- Defined:
  - Each sample is replaced by its absolute value before accumulation. |-32768| = 32768 as an unsigned DATA_W+1 value.
  - The accumulator and io_out_bits are unsigned, giving a sum of absolute differences. Max 16*32768 = 524288 fits in 20 bits.
- Undefined: signed two's-complement accumulation as described above.
- All handshake, flush and reset behaviour is identical in both builds.

Test Plan:
- Basic signed sum: WINDOW=16, io_out_ready=1, samples 1,2,...,16 streamed every cycle -> one cycle after the 16th accept, io_out_valid=1 and io_out_bits=136. Afterwards io_count=0.
- Negative extremes: 16 samples of 0x8000 -> io_out_bits=20'h80000 (-524288). With MINUS_DIFF_ACC_ABS_EN, the same stimulus gives 524288 unsigned (20'h80000) and 16 samples of 0xFFFF give 16.
- Backpressure: complete a window with io_out_ready=0 for 5 cycles while io_in_valid=1 -> io_in_ready=0, and io_out_bits is stable for all 5 cycles. Raising io_out_ready gives one output handshake, then accepts resume the same cycle.
- Back-to-back windows: 32 samples of value 3 with io_out_ready=1 -> two outputs of 48. The second appears exactly 16 cycles after the first, with no bubble on io_in_ready.
- Flush: 5 samples of 10, then io_flush for 1 cycle with io_in_valid=1, then 16 samples of 1 -> io_in_ready=0 during the flush cycle, io_count returns to 0, and the output is 16 (not 66).
- Reset mid-window: 7 samples accepted, then reset pulsed low asynchronously between edges -> io_count and io_out_valid go to 0 immediately, and the next 16 samples of 2 give 32.
